dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
- Posted-store write buffer between the MEM-stage pipeline register and the 1024x32 data memory.
- Accepts stores from the pipeline in one cycle and drains them to data memory when no load is using the port.
- Forwards buffered data to younger loads so the pipeline never reads stale memory.
- Drives the data memory's write enable, read enable, address and write-data inputs directly.

Parameters:
- DEPTH, 4, buffer entries; power of two, 2..16.
- ADDR_WIDTH, 10, word address width.
- DATA_WIDTH, 32, data word width.

Ports:
- i_CLK  in  1  clock, all state on rising edge.
- i_RST_n  in  1  asynchronous active-low reset.
- i_Store_Valid  in  1  MEM stage presents a store.
- i_Store_Address  in  ADDR_WIDTH  store word address.
- i_Store_Data  in  DATA_WIDTH  store data.
- o_Store_Ready  out  1  buffer can accept; the store is taken on a rising edge when valid and ready.
- i_Load_Valid  in  1  MEM stage performs a load this cycle.
- i_Load_Address  in  ADDR_WIDTH  load word address.
- i_Mem_Read_Data  in  DATA_WIDTH  combinational read data returned by data memory.
- o_Load_Data  out  DATA_WIDTH  merged load result.
- o_Load_Hit  out  1  load was satisfied from the buffer.
- o_MemWrite  out  1  data memory write enable.
- o_MemRead  out  1  data memory read enable.
- o_Address  out  ADDR_WIDTH  data memory address.
- o_Write_Data  out  DATA_WIDTH  data memory write data.
- o_Empty  out  1  no pending stores; used by the pipeline for fence/halt.
- o_Count  out  clog2(DEPTH)+1  occupancy.

Behaviour:
- Storage: circular FIFO with per-entry valid, address and data.
  - Read and write pointers are clog2(DEPTH)+1 bits wide; the extra bit distinguishes full from empty.
  - full = count==DEPTH; empty = count==0.
- Reset (async, i_RST_n low):
  - Pointers, count and all valid bits are cleared immediately.
  - Pending stores are discarded.
  - Outputs while in reset: o_Store_Ready=1, o_Empty=1, o_Count=0, o_MemWrite=0, o_MemRead=0, o_Load_Hit=0.
  - Reset deassertion takes effect at the next edge; no other reset-mid-operation handling is required.
- Port arbitration (combinational). The load has priority over the drain.
  - If i_Load_Valid: o_MemRead=1, o_MemWrite=0, o_Address=i_Load_Address.
  - Else if !empty: o_MemWrite=1, o_MemRead=0, o_Address=head address, o_Write_Data=head data.
  - Else: both enables are 0, and o_Address/o_Write_Data show head fields (don't-care).
  - o_MemWrite and o_MemRead are never both 1.
- Drain: on each rising edge with o_MemWrite=1, the head is popped (valid cleared, read pointer +1 with wrap). The memory captures the write on that same edge.
- Enqueue: on a rising edge with i_Store_Valid && o_Store_Ready, the store is written at the tail and the write pointer advances with wrap.
  - o_Store_Ready = !full. A pop in the same cycle does not make a full buffer ready.
- Latency: a store accepted at edge N reaches memory at edge N+1 at the earliest. Each cycle with i_Load_Valid=1 adds one cycle.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Forwarding (combinational):
  - Compare i_Load_Address against all valid entries; the youngest match (nearest the tail) wins.
  - On a hit: o_Load_Hit=1, o_Load_Data=entry data.
  - On a miss: o_Load_Hit=0, o_Load_Data=i_Mem_Read_Data.
  - A store being enqueued in the same cycle is NOT forwarded. Same-cycle store-to-load forwarding is the pipeline's responsibility.
  - When i_Load_Valid=0: o_Load_Hit=0, o_Load_Data=i_Mem_Read_Data.
- Duplicate addresses: without merging, each store gets its own entry. Entries drain in program order, so the last store wins in memory.

Optional Feature:
- Macro: DMEM_STORE_BUFFER_MERGE_EN.
- Defined: an incoming store whose address matches a valid entry overwrites that entry's data in place; no allocation, count unchanged.
  - The match must not be against the head being popped in the same cycle. If the only match is that head, a new entry is allocated.
  - o_Store_Ready = !full || (merge match exists).
- Undefined: no merging; behaviour exactly as above.

Test Plan:
- Single store: store addr 0x010 data 0xDEADBEEF, no loads -> o_MemWrite=1 next cycle with o_Address=0x010; memory word 0x010 = 0xDEADBEEF; o_Empty=1 afterwards.
- Fill and back-pressure: hold i_Load_Valid=1 and push 4 stores -> o_Count=4, o_Store_Ready=0, fifth store not accepted. Release load -> 4 writes in order on consecutive cycles, o_Count goes 3,2,1,0.
- Forwarding: store 0x020=0x11, then 0x020=0x22, load 0x020 with drain stalled -> o_Load_Hit=1, o_Load_Data=0x22. Load 0x021 -> o_Load_Hit=0, o_Load_Data=i_Mem_Read_Data.
- Arbitration: buffer non-empty and i_Load_Valid=1 -> o_MemRead=1, o_MemWrite=0, no pop. Next cycle load low -> pop occurs.
- Async reset: with 3 pending stores, pull i_RST_n low mid-cycle -> o_Empty=1, o_Count=0, o_MemWrite=0 immediately; no further writes after release.
- With DMEM_STORE_BUFFER_MERGE_EN, buffer full with stall: store to an address already held -> accepted, data replaced, o_Count stays 4. After drain, memory holds the merged value.

Source files
------------

// File: rtl/dmem_store_buffer_if.sv
// dmem_store_buffer_if: pipeline-side store/load bus and data-memory port of the posted-store buffer.
// master = pipeline/memory environment, slave = the buffer.
interface dmem_store_buffer_if #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic                  i_Store_Valid;
  logic [ADDR_WIDTH-1:0] i_Store_Address;
  logic [DATA_WIDTH-1:0] i_Store_Data;
  logic                  o_Store_Ready;
  logic                  i_Load_Valid;
  logic [ADDR_WIDTH-1:0] i_Load_Address;
  logic [DATA_WIDTH-1:0] i_Mem_Read_Data;
  logic [DATA_WIDTH-1:0] o_Load_Data;
  logic                  o_Load_Hit;
  logic                  o_MemWrite;
  logic                  o_MemRead;
  logic [ADDR_WIDTH-1:0] o_Address;
  logic [DATA_WIDTH-1:0] o_Write_Data;
  logic                  o_Empty;
  logic [CW-1:0]         o_Count;
  modport master (
    output i_Store_Valid, i_Store_Address, i_Store_Data, i_Load_Valid, i_Load_Address, i_Mem_Read_Data,
    input  o_Store_Ready, o_Load_Data, o_Load_Hit, o_MemWrite, o_MemRead, o_Address, o_Write_Data, o_Empty, o_Count
  );
  modport slave (
    input  i_Store_Valid, i_Store_Address, i_Store_Data, i_Load_Valid, i_Load_Address, i_Mem_Read_Data,
    output o_Store_Ready, o_Load_Data, o_Load_Hit, o_MemWrite, o_MemRead, o_Address, o_Write_Data, o_Empty, o_Count
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-store FIFO in front of data memory with youngest-match load forwarding.
// Define DMEM_STORE_BUFFER_MERGE_EN to merge stores into an already-buffered entry of the same address.
module dmem_store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic i_CLK,
  input logic i_RST_n,
  dmem_store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic [PW:0]           wp, rp, cnt;
  logic [DEPTH-1:0]      vld;
  logic [ADDR_WIDTH-1:0] adr [DEPTH];
  logic [DATA_WIDTH-1:0] dat [DEPTH];
  logic [PW-1:0]         hd, tl, fsel;
  logic                  full, empty, lv, pop, ready, push, alloc, mhit, fhit;
  assign hd    = rp[PW-1:0];
  assign tl    = wp[PW-1:0];
  assign full  = cnt[PW];
  assign empty = cnt == '0;
  assign lv    = bus.i_Load_Valid && i_RST_n;
  assign pop   = !lv && !empty;
  assign ready = !full || mhit;
  assign push  = bus.i_Store_Valid && ready;
  assign alloc = push && !mhit;
  // Scan oldest to youngest so the last match seen is the youngest entry.
  always_comb begin
    fhit = 1'b0;
    fsel = hd;
    for (int k = 0; k < DEPTH; k++)
      if (vld[hd + PW'(k)] && adr[hd + PW'(k)] == bus.i_Load_Address) begin
        fhit = 1'b1;
        fsel = hd + PW'(k);
      end
  end
`ifdef DMEM_STORE_BUFFER_MERGE_EN
  logic [PW-1:0] msel;
  // The head leaving this cycle cannot absorb a merge; a new entry is allocated instead.
  always_comb begin
    mhit = 1'b0;
    msel = hd;
    for (int k = 0; k < DEPTH; k++)
      if (!(pop && k == 0) && vld[hd + PW'(k)] && adr[hd + PW'(k)] == bus.i_Store_Address) begin
        mhit = 1'b1;
        msel = hd + PW'(k);
      end
  end
`else
  assign mhit = 1'b0;
`endif
  assign bus.o_Store_Ready = ready;
  assign bus.o_Load_Hit    = lv && fhit;
  assign bus.o_Load_Data   = (lv && fhit) ? dat[fsel] : bus.i_Mem_Read_Data;
  assign bus.o_MemRead     = lv;
  assign bus.o_MemWrite    = pop;
  assign bus.o_Address     = lv ? bus.i_Load_Address : adr[hd];
  assign bus.o_Write_Data  = dat[hd];
  assign bus.o_Empty       = empty;
  assign bus.o_Count       = cnt;
  always_ff @(posedge i_CLK or negedge i_RST_n)
    if (!i_RST_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      vld <= '0;
    end else begin
      if (pop) begin
        vld[hd] <= 1'b0;
        rp      <= rp + 1'b1;
      end
      if (alloc) begin
        vld[tl] <= 1'b1;
        wp      <= wp + 1'b1;
      end
      cnt <= cnt + {{PW{1'b0}}, alloc} - {{PW{1'b0}}, pop};
    end
  always_ff @(posedge i_CLK)
    if (alloc) begin
      adr[tl] <= bus.i_Store_Address;
      dat[tl] <= bus.i_Store_Data;
    end
`ifdef DMEM_STORE_BUFFER_MERGE_EN
    else if (push)
      dat[msel] <= bus.i_Store_Data;
`endif
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: scoreboard bench with a data-memory model; every cycle checks arbitration,
// forwarding, occupancy and the order/content of drained writes.
module tb_dmem_store_buffer;
  localparam int DEPTH = 4, AW = 10, DW = 32;
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} st_t;
  logic i_CLK = 1'b0;
  logic i_RST_n = 1'b0;
  always #5 i_CLK = ~i_CLK;
  dmem_store_buffer_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_CLK(i_CLK),
    .i_RST_n(i_RST_n),
    .bus(bus)
  );
  logic [DW-1:0] mem [1024];
  st_t q[$];
  int tests = 0, fails = 0, nwr = 0;
  int n, mi, w0;
  logic hit, mm;
  logic [DW-1:0] fd;
  function automatic logic [DW-1:0] initv(input int i);
    return 32'hA5A50000 ^ (32'(i) * 32'h00010003);
  endfunction
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask
  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.i_Store_Valid = 1'b1;
    bus.i_Store_Address = a;
    bus.i_Store_Data = d;
    tick();
    bus.i_Store_Valid = 1'b0;
  endtask
  task automatic drain();
    for (int k = 0; k < 64 && !bus.o_Empty; k++) tick();
    check("drain_done", bus.o_Empty, 1);
  endtask
  initial for (int i = 0; i < 1024; i++) mem[i] = initv(i);
  assign bus.i_Mem_Read_Data = mem[bus.o_Address];
  always @(posedge i_CLK)
    if (i_RST_n && bus.o_MemWrite) begin
      mem[bus.o_Address] <= bus.o_Write_Data;
      nwr <= nwr + 1;
    end
  // Scoreboard: q holds the stores the buffer should currently hold, oldest first.
  always @(negedge i_CLK) begin
    if (!i_RST_n) q.delete();
    else begin
      n = q.size();
      check("count", bus.o_Count, n);
      check("empty", bus.o_Empty, n == 0);
      if (bus.i_Load_Valid) begin
        hit = 1'b0;
        fd = mem[bus.i_Load_Address];
        foreach (q[i]) if (q[i].a == bus.i_Load_Address) begin hit = 1'b1; fd = q[i].d; end
        check("memread", bus.o_MemRead, 1);
        check("memwrite_during_load", bus.o_MemWrite, 0);
        check("load_addr", bus.o_Address, bus.i_Load_Address);
        check("load_hit", bus.o_Load_Hit, hit);
        check("load_data", bus.o_Load_Data, fd);
      end else begin
        check("load_hit_idle", bus.o_Load_Hit, 0);
        check("memread_idle", bus.o_MemRead, 0);
        check("memwrite", bus.o_MemWrite, n != 0);
        if (n != 0) begin
          check("wr_addr", bus.o_Address, q[0].a);
          check("wr_data", bus.o_Write_Data, q[0].d);
          void'(q.pop_front());
        end
      end
      mm = 1'b0;
      mi = -1;
`ifdef DMEM_STORE_BUFFER_MERGE_EN
      for (int i = q.size() - 1; i >= 0; i--)
        if (mi < 0 && q[i].a == bus.i_Store_Address) mi = i;
      mm = mi >= 0;
`endif
      check("store_ready", bus.o_Store_Ready, n < DEPTH || mm);
      if (bus.i_Store_Valid && (n < DEPTH || mm)) begin
        if (mm) q[mi].d = bus.i_Store_Data;
        else q.push_back({bus.i_Store_Address, bus.i_Store_Data});
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.i_Store_Valid = 1'b0;
    bus.i_Store_Address = '0;
    bus.i_Store_Data = '0;
    bus.i_Load_Valid = 1'b1;
    bus.i_Load_Address = '0;
    #12;
    check("rst_ready", bus.o_Store_Ready, 1);
    check("rst_empty", bus.o_Empty, 1);
    check("rst_count", bus.o_Count, 0);
    check("rst_memwrite", bus.o_MemWrite, 0);
    check("rst_memread", bus.o_MemRead, 0);
    check("rst_load_hit", bus.o_Load_Hit, 0);
    tick();
    bus.i_Load_Valid = 1'b0;
    i_RST_n = 1'b1;
    tick();
    // single store drains on the following edge
    store(10'h010, 32'hDEADBEEF);
    check("single_memwrite", bus.o_MemWrite, 1);
    check("single_addr", bus.o_Address, 10'h010);
    tick();
    check("single_empty_after", bus.o_Empty, 1);
    check("single_mem", mem[10'h010], 32'hDEADBEEF);
    // fill under a held load, then release
    bus.i_Load_Valid = 1'b1;
    bus.i_Load_Address = 10'h3FF;
    for (int i = 0; i < 4; i++) store(10'h100 + 10'(i), 32'h1000 + 32'(i));
    check("fill_count", bus.o_Count, 4);
    check("fill_ready", bus.o_Store_Ready, 0);
    store(10'h104, 32'h1004);
    check("fill_fifth_rejected", bus.o_Count, 4);
    bus.i_Load_Valid = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      tick();
      check("drain_count", bus.o_Count, k);
    end
    check("fill_mem_last", mem[10'h103], 32'h1003);
    check("fifth_not_written", mem[10'h104], initv(10'h104));
    // forwarding with drain stalled
    bus.i_Load_Valid = 1'b1;
    bus.i_Load_Address = 10'h020;
    store(10'h020, 32'h11);
    store(10'h020, 32'h22);
    check("fwd_hit", bus.o_Load_Hit, 1);
    check("fwd_data", bus.o_Load_Data, 32'h22);
    bus.i_Load_Address = 10'h021;
    #1;
    check("fwd_miss_hit", bus.o_Load_Hit, 0);
    check("fwd_miss_data", bus.o_Load_Data, initv(10'h021));
    bus.i_Load_Valid = 1'b0;
    drain();
    check("fwd_mem_final", mem[10'h020], 32'h22);
    // arbitration: load blocks the drain for one cycle
    store(10'h030, 32'h33);
    bus.i_Load_Valid = 1'b1;
    bus.i_Load_Address = 10'h031;
    #1;
    check("arb_memread", bus.o_MemRead, 1);
    check("arb_memwrite", bus.o_MemWrite, 0);
    tick();
    check("arb_no_pop", bus.o_Count, 1);
    bus.i_Load_Valid = 1'b0;
    #1;
    check("arb_memwrite_next", bus.o_MemWrite, 1);
    tick();
    check("arb_popped", bus.o_Count, 0);
    // async reset discards pending stores
    bus.i_Load_Valid = 1'b1;
    for (int i = 0; i < 3; i++) store(10'h040 + 10'(i), 32'h4000 + 32'(i));
    check("rst_pending", bus.o_Count, 3);
    w0 = nwr;
    bus.i_Load_Valid = 1'b0;
    #2;
    i_RST_n = 1'b0;
    #1;
    check("arst_empty", bus.o_Empty, 1);
    check("arst_count", bus.o_Count, 0);
    check("arst_memwrite", bus.o_MemWrite, 0);
    check("arst_ready", bus.o_Store_Ready, 1);
    tick();
    i_RST_n = 1'b1;
    repeat (5) tick();
    check("arst_no_writes", nwr, w0);
    check("arst_mem_untouched", mem[10'h040], initv(10'h040));
`ifdef DMEM_STORE_BUFFER_MERGE_EN
    bus.i_Load_Valid = 1'b1;
    bus.i_Load_Address = 10'h3FF;
    for (int i = 0; i < 4; i++) store(10'h200 + 10'(i), 32'h2000 + 32'(i));
    bus.i_Store_Valid = 1'b1;
    bus.i_Store_Address = 10'h201;
    bus.i_Store_Data = 32'hCAFE;
    #1;
    check("merge_ready_full", bus.o_Store_Ready, 1);
    tick();
    bus.i_Store_Valid = 1'b0;
    check("merge_count", bus.o_Count, 4);
    bus.i_Load_Valid = 1'b0;
    drain();
    check("merge_mem", mem[10'h201], 32'hCAFE);
`endif
    // random traffic over a small address window
    for (int i = 0; i < 400; i++) begin
      bus.i_Store_Valid = 1'($urandom_range(0, 1));
      bus.i_Store_Address = 10'h050 + 10'($urandom_range(0, 7));
      bus.i_Store_Data = $urandom;
      bus.i_Load_Valid = $urandom_range(0, 2) == 0;
      bus.i_Load_Address = 10'h050 + 10'($urandom_range(0, 7));
      tick();
    end
    bus.i_Store_Valid = 1'b0;
    bus.i_Load_Valid = 1'b0;
    drain();
    tick();
    check("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
